ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 27 ++
 rtl/ram_arb_rsp_pipe.sv | 58 +++++
 rtl/ram_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Brief    : Shared types and default widths for the two-port RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  // Default RAM geometry
  localparam int unsigned c_ADDR_W = 5;
  localparam int unsigned c_DATA_W = 8;

  // Arbitration FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_t;

  // Requester identity, used for last_owner and the return pipeline tag
  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arb_rsp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_rsp_pipe
// Brief    : Two-stage read-return tracker. Tags each granted access with its
//            owner and direction, and routes ram_rd_data back two cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arb_rsp_pipe
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = c_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_issue,
  input  owner_t            i_owner,
  input  logic              i_is_read,
  input  logic [DATA_W-1:0] i_ram_rd_data,
  output logic              o_rvalid_a,
  output logic              o_rvalid_b,
  output logic [DATA_W-1:0] o_rd_data
);

  logic   r_v1;
  owner_t r_own1;
  logic   r_rd1;
  logic   r_v2;
  owner_t r_own2;
  logic   r_rd2;
  logic   w_ret;

  // Shift the access tag along with the RAM command and RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_own1 <= OWNER_A;
      r_rd1  <= 1'b0;
      r_v2   <= 1'b0;
      r_own2 <= OWNER_A;
      r_rd2  <= 1'b0;
    end else begin
      r_v1   <= i_issue;
      r_own1 <= i_owner;
      r_rd1  <= i_is_read;
      r_v2   <= r_v1;
      r_own2 <= r_own1;
      r_rd2  <= r_rd1;
    end
  end

  // The tag, not the current FSM owner, decides who receives the data
  assign w_ret      = r_v2 & r_rd2;
  assign o_rvalid_a = w_ret & (r_own2 == OWNER_A);
  assign o_rvalid_b = w_ret & (r_own2 == OWNER_B);
  assign o_rd_data  = w_ret ? i_ram_rd_data : '0;

endmodule : ram_arb_rsp_pipe
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Arbitrates two requesters onto one single-port RAM with a bounded
//            burst length, registered RAM command and tagged read return.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = c_ADDR_W,
  parameter int DATA_W    = c_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  owner_t            r_last;
  owner_t            w_last_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_burst_done;
  logic              w_gnt_a;
  logic              w_gnt_b;

  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wr_data;

  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_burst_done = (w_cnt_inc == CNT_W'(MAX_BURST));

  // FSM, burst counter and last_owner state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= OWNER_B;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, grant and counter logic; a full burst yields only to a waiter
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_gnt_a     = 1'b0;
    w_gnt_b     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (req_a && req_b) begin
          w_state_nxt = (r_last == OWNER_B) ? ST_OWN_A : ST_OWN_B;
        end else if (req_a) begin
          w_state_nxt = ST_OWN_A;
        end else if (req_b) begin
          w_state_nxt = ST_OWN_B;
        end
      end
      ST_OWN_A: begin
        w_gnt_a = req_a;
        if (!req_a) begin
          w_cnt_nxt   = '0;
          w_last_nxt  = OWNER_A;
          w_state_nxt = req_b ? ST_OWN_B : ST_IDLE;
        end else if (w_burst_done) begin
          w_cnt_nxt = '0;
          if (req_b) begin
            w_last_nxt  = OWNER_A;
            w_state_nxt = ST_OWN_B;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_OWN_B: begin
        w_gnt_b = req_b;
        if (!req_b) begin
          w_cnt_nxt   = '0;
          w_last_nxt  = OWNER_B;
          w_state_nxt = req_a ? ST_OWN_A : ST_IDLE;
        end else if (w_burst_done) begin
          w_cnt_nxt = '0;
          if (req_a) begin
            w_last_nxt  = OWNER_B;
            w_state_nxt = ST_OWN_A;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // RAM command register: capture the granted access, else idle with addr/data held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_en      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_wr_data <= '0;
    end else if (w_gnt_a) begin
      r_ram_en      <= 1'b1;
      r_ram_we      <= we_a;
      r_ram_addr    <= addr_a;
      r_ram_wr_data <= wdata_a;
    end else if (w_gnt_b) begin
      r_ram_en      <= 1'b1;
      r_ram_we      <= we_b;
      r_ram_addr    <= addr_b;
      r_ram_wr_data <= wdata_b;
    end else begin
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
    end
  end

  assign gnt_a       = w_gnt_a;
  assign gnt_b       = w_gnt_b;
  assign ram_en      = r_ram_en;
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_wr_data = r_ram_wr_data;

  ram_arb_rsp_pipe #(
    .DATA_W (DATA_W)
  ) u_rsp_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_issue       (w_gnt_a | w_gnt_b),
    .i_owner       (w_gnt_b ? OWNER_B : OWNER_A),
    .i_is_read     (w_gnt_a ? ~we_a : ~we_b),
    .i_ram_rd_data (ram_rd_data),
    .o_rvalid_a    (rvalid_a),
    .o_rvalid_b    (rvalid_b),
    .o_rd_data     (rd_data)
  );

endmodule : ram_port_arbiter
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            against a rule-level arbiter/memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int c_MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b, we_a, we_b;
  logic [4:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0] rd_data;
  logic       ram_en, ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_wr_data;
  logic [7:0] ram_rd_data;

  int errors = 0;
  int checks = 0;

  // RAM content: untouched locations read their power-on pattern
  bit [7:0]  mem [32];
  bit [31:0] written;
  // Bench view of the memory, updated in grant order
  bit [7:0]  shadow [32];
  bit [31:0] sh_written;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(5), .DATA_W(8), .MAX_BURST(c_MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rd_data(rd_data), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 7 + 1);
  endfunction

  function automatic logic [7:0] exp_mem(input int a);
    return sh_written[a] ? shadow[a] : init_val(a);
  endfunction

  // Single-port synchronous RAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]     <= ram_wr_data;
        written[ram_addr] <= 1'b1;
      end else begin
        ram_rd_data <= written[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
      end
    end
  end

  task automatic clear_inputs();
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
  endtask

  // Leaves the bench at posedge+1 of the first cycle after reset release
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++; if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin errors++; $display("FAIL reset_gnt: got a=%b b=%b want 0 0", gnt_a, gnt_b); end
    checks++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got a=%b b=%b want 0 0", rvalid_a, rvalid_b); end
    checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_ctl: got en=%b we=%b want 0 0", ram_en, ram_we); end
    checks++; if (ram_addr !== 5'd0 || ram_wr_data !== 8'd0 || rd_data !== 8'd0) begin errors++; $display("FAIL reset_data: got addr=%h wd=%h rd=%h want 0", ram_addr, ram_wr_data, rd_data); end
  endtask

  task automatic test_single_read();
    do_reset();
    req_a = 1; we_a = 0; addr_a = 5; #2;
    checks++; if (gnt_a !== 1'b0) begin errors++; $display("FAIL sr_arb_latency: got gnt_a=%b want 0", gnt_a); end
    next_cycle(); #2;
    checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin errors++; $display("FAIL sr_gnt: got a=%b b=%b want 1 0", gnt_a, gnt_b); end
    next_cycle(); req_a = 0; #2;
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 5'd5) begin errors++; $display("FAIL sr_cmd: got en=%b we=%b addr=%0d want 1 0 5", ram_en, ram_we, ram_addr); end
    checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL sr_early_rvalid: got %b want 0", rvalid_a); end
    next_cycle(); #2;
    checks++; if (rvalid_a !== 1'b1 || rvalid_b !== 1'b0) begin errors++; $display("FAIL sr_rvalid: got a=%b b=%b want 1 0", rvalid_a, rvalid_b); end
    checks++; if (rd_data !== exp_mem(5)) begin errors++; $display("FAIL sr_rd_data: got %h want %h", rd_data, exp_mem(5)); end
    next_cycle(); #2;
    checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL sr_rvalid_pulse: got %b want 0", rvalid_a); end
  endtask

  task automatic test_write_read();
    do_reset();
    req_a = 1; we_a = 1; addr_a = 31; wdata_a = 8'h3C; #2;
    next_cycle(); #2;
    checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", gnt_a); end
    shadow[31] = 8'h3C; sh_written[31] = 1'b1;
    next_cycle(); we_a = 0; #2;
    checks++; if (gnt_a !== 1'b1 || ram_we !== 1'b1 || ram_wr_data !== 8'h3C) begin errors++; $display("FAIL rd_gnt_wcmd: got gnt=%b we=%b wd=%h want 1 1 3c", gnt_a, ram_we, ram_wr_data); end
    next_cycle(); req_a = 0; #2;
    checks++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got a=%b b=%b want 0 0", rvalid_a, rvalid_b); end
    next_cycle(); #2;
    checks++; if (rvalid_a !== 1'b1 || rd_data !== 8'h3C) begin errors++; $display("FAIL wr_readback: got rv=%b data=%h want 1 3c", rvalid_a, rd_data); end
  endtask

  task automatic test_tie();
    do_reset();
    req_a = 1; req_b = 1; #2;
    checks++; if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin errors++; $display("FAIL tie_idle: got a=%b b=%b want 0 0", gnt_a, gnt_b); end
    next_cycle(); #2;
    checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin errors++; $display("FAIL tie_first: got a=%b b=%b want 1 0", gnt_a, gnt_b); end
    next_cycle(); req_a = 0; #2;
    next_cycle(); #2;
    checks++; if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin errors++; $display("FAIL tie_handover: got a=%b b=%b want 0 1", gnt_a, gnt_b); end
  endtask

  task automatic test_burst();
    string pat;
    pat = "AAAABBBBAAAA";
    do_reset();
    req_a = 1; req_b = 1; addr_a = 1; addr_b = 2; #2;
    for (int i = 0; i < 12; i++) begin
      next_cycle(); #2;
      checks++;
      if (gnt_a !== (pat[i] == "A") || gnt_b !== (pat[i] == "B")) begin
        errors++; $display("FAIL burst_pattern[%0d]: got a=%b b=%b want %s", i, gnt_a, gnt_b, pat.substr(i, i));
      end
      if (i > 0) begin
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== ((pat[i-1] == "A") ? 5'd1 : 5'd2)) begin
          errors++; $display("FAIL burst_throughput[%0d]: got en=%b addr=%0d", i, ram_en, ram_addr);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_lone_b();
    do_reset();
    req_b = 1; addr_b = 9; #2;
    for (int i = 0; i < 10; i++) begin
      next_cycle(); #2;
      checks++; if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin errors++; $display("FAIL lone_b[%0d]: got a=%b b=%b want 0 1", i, gnt_a, gnt_b); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    req_a = 1; we_a = 0; addr_a = 7; #2;
    next_cycle(); #2;
    checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL rmr_gnt: got %b want 1", gnt_a); end
    next_cycle(); req_a = 0; rst_n = 0; #1;
    checks++;
    if ({gnt_a, gnt_b, rvalid_a, rvalid_b, ram_en, ram_we} !== 6'b0 || ram_addr !== 5'd0 || ram_wr_data !== 8'd0 || rd_data !== 8'd0) begin
      errors++; $display("FAIL rmr_outputs: got gnt=%b%b rv=%b%b en=%b we=%b addr=%h rd=%h want all 0",
                         gnt_a, gnt_b, rvalid_a, rvalid_b, ram_en, ram_we, ram_addr, rd_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin errors++; $display("FAIL rmr_stale_rvalid[%0d]: got a=%b b=%b want 0 0", i, rvalid_a, rvalid_b); end
      next_cycle();
    end
    req_a = 1; req_b = 1; #2;
    next_cycle(); #2;
    checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin errors++; $display("FAIL rmr_tie: got a=%b b=%b want 1 0", gnt_a, gnt_b); end
    clear_inputs();
  endtask

  // Random traffic: owner/run-length model for grants, grant-ordered memory for data
  task automatic test_random();
    int m_own, m_last, m_cnt, other;
    bit own_req, oth_req, e_ga, e_gb;
    bit sv[4]; int sown[4]; logic [7:0] sdat[4];
    bit p_en, p_we; logic [4:0] p_addr; logic [7:0] p_wd;
    do_reset();
    m_own = 0; m_last = 2; m_cnt = 0; p_en = 0; p_we = 0; p_addr = 0; p_wd = 0;
    for (int k = 0; k < 4; k++) begin sv[k] = 0; sown[k] = 0; sdat[k] = 0; end
    for (int c = 0; c < 600; c++) begin
      req_a = ($urandom_range(0, 3) != 0); req_b = ($urandom_range(0, 3) != 0);
      we_a = $urandom_range(0, 1) == 1; we_b = $urandom_range(0, 1) == 1;
      addr_a = 5'($urandom); addr_b = 5'($urandom);
      wdata_a = 8'($urandom); wdata_b = 8'($urandom);
      #2;
      e_ga = (m_own == 1) && req_a;
      e_gb = (m_own == 2) && req_b;
      checks++; if (gnt_a !== e_ga || gnt_b !== e_gb) begin errors++; $display("FAIL rnd_gnt c=%0d: got a=%b b=%b want %b %b", c, gnt_a, gnt_b, e_ga, e_gb); end
      checks++; if (ram_en !== p_en || ram_we !== (p_en & p_we)) begin errors++; $display("FAIL rnd_ram_ctl c=%0d: got en=%b we=%b want %b %b", c, ram_en, ram_we, p_en, p_en & p_we); end
      if (p_en) begin
        checks++; if (ram_addr !== p_addr || (p_we && ram_wr_data !== p_wd)) begin errors++; $display("FAIL rnd_ram_cmd c=%0d: got addr=%h wd=%h want %h %h", c, ram_addr, ram_wr_data, p_addr, p_wd); end
      end
      checks++;
      if (rvalid_a !== (sv[c%4] && sown[c%4] == 1) || rvalid_b !== (sv[c%4] && sown[c%4] == 2)) begin
        errors++; $display("FAIL rnd_rvalid c=%0d: got a=%b b=%b want owner %0d", c, rvalid_a, rvalid_b, sv[c%4] ? sown[c%4] : 0);
      end
      if (sv[c%4]) begin
        checks++; if (rd_data !== sdat[c%4]) begin errors++; $display("FAIL rnd_rd_data c=%0d: got %h want %h", c, rd_data, sdat[c%4]); end
      end
      sv[c%4] = 0;
      // Record the access the model granted this cycle
      p_en = e_ga || e_gb;
      if (p_en) begin
        p_we = e_ga ? we_a : we_b; p_addr = e_ga ? addr_a : addr_b; p_wd = e_ga ? wdata_a : wdata_b;
        if (p_we) begin
          shadow[p_addr] = p_wd; sh_written[p_addr] = 1'b1;
        end else begin
          sv[(c+2)%4] = 1; sown[(c+2)%4] = e_ga ? 1 : 2; sdat[(c+2)%4] = exp_mem(int'(p_addr));
        end
      end
      // Ownership rules: tie goes away from last owner, drop hands over, full burst yields
      if (m_own == 0) begin
        if (req_a && req_b) m_own = (m_last == 1) ? 2 : 1;
        else if (req_a)     m_own = 1;
        else if (req_b)     m_own = 2;
        m_cnt = 0;
      end else begin
        own_req = (m_own == 1) ? req_a : req_b;
        oth_req = (m_own == 1) ? req_b : req_a;
        other   = 3 - m_own;
        if (!own_req) begin
          m_last = m_own; m_own = oth_req ? other : 0; m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt == c_MAX_BURST) begin
            m_cnt = 0;
            if (oth_req) begin m_last = m_own; m_own = other; end
          end
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_read();
    test_tie();
    test_burst();
    test_lone_b();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ram_port_arbiter
`default_nettype wire
